// File: rtl/ahb_banked_rom_if.sv
// AHB-Lite slave-side bundle for the banked ROM.
interface ahb_banked_rom_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_banked_rom.sv
// AHB-Lite ROM split into NBANKS banks, one enabled per read.
// Define AHB_ROM_ERROR_EN to answer writes/misaligned accesses with ERROR.
module ahb_banked_rom #(
    parameter int    MEMWIDTH    = 14,
    parameter int    NBANKS      = 4,
    parameter int    WAIT_STATES = 0,
    parameter string ROM_FILE    = "rom.hex"
) (
    input logic             HCLK,
    input logic             HRESET,
    ahb_banked_rom_if.slave bus
);
    localparam int DEPTH = 2 ** (MEMWIDTH - 2);
    localparam int AW    = MEMWIDTH - 2;
    localparam int BW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    typedef logic [31:0] rom_t [DEPTH];

    rom_t rom = '{default: '0};

    state_t state, state_nx;
    logic [1:0] cnt, cnt_nx;
    logic pend_q, pend_nx;
    logic accept, is_read, err;
    logic [AW-1:0] widx;
    logic [BW-1:0] bidx;
    logic [NBANKS-1:0] bank_en;
    logic [NBANKS-1:0][31:0] bank_data;

    logic [AW-1:0] addr_q;
    logic [BW-1:0] bank_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [1:0]    lane_q;

    assign widx = bus.HADDR[MEMWIDTH-1:2];
    assign bidx = (NBANKS > 1) ? bus.HADDR[MEMWIDTH-1 -: BW] : '0;

    // A new address phase is only taken when the previous one has completed
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & ~HRESET
                  & ((state == IDLE) | (state == ERR2));

`ifdef AHB_ROM_ERROR_EN
    logic misalign;

    always_comb begin
        unique case (bus.HSIZE)
            3'd0:    misalign = 1'b0;
            3'd1:    misalign = bus.HADDR[0];
            default: misalign = |bus.HADDR[1:0];
        endcase
    end

    assign err = bus.HWRITE | misalign;
`else
    assign err = 1'b0;
`endif

    assign is_read = accept & ~bus.HWRITE & ~err;
    assign bank_en = NBANKS'(is_read) << bidx;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bank_data <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (bank_en[b]) bank_data[b] <= rom[widx];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= '0;
            bank_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
        end else if (accept) begin
            addr_q  <= widx;
            bank_q  <= bidx;
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            lane_q  <= bus.HADDR[1:0];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            pend_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pend_q <= pend_nx;
        end
    end

    // pend marks that the next IDLE cycle completes a read and drives data
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend_q;
        unique case (state)
            IDLE, ERR2: begin
                state_nx = IDLE;
                pend_nx  = 1'b0;
                if (accept && err) begin
                    state_nx = ERR1;
                end else if (is_read) begin
                    pend_nx = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = 2'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt <= 2'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            ERR1: state_nx = ERR2;
        endcase
    end

    assign bus.HREADYOUT = HRESET | (state == IDLE) | (state == ERR2);
    assign bus.HRDATA    = (!HRESET && state == IDLE && pend_q)
                         ? bank_data[bank_q] : '0;

`ifdef AHB_ROM_ERROR_EN
    assign bus.HRESP = ~HRESET & ((state == ERR1) | (state == ERR2));
`else
    assign bus.HRESP = 1'b0;
`endif

    logic unused;
    assign unused = ^{addr_q, write_q, size_q, lane_q, bus.HWDATA,
                      bus.HADDR[31:MEMWIDTH], bus.HSIZE, bus.HTRANS[0]};
endmodule

// File: tb/tb_ahb_banked_rom.sv
// Directed bench: three ROM instances with 0, 2 and 3 wait states.
module tb_ahb_banked_rom;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rsts;
    logic [2:0]  sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;

    logic        rdy   [3];
    logic        resp  [3];
    logic [31:0] rdata [3];
    logic [3:0]  ben   [3];

    int checks = 0;
    int errors = 0;

    ahb_banked_rom_if bus [3] ();

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int WS = (i == 0) ? 0 : ((i == 1) ? 2 : 3);

        assign bus[i].HSEL   = sel[i];
        assign bus[i].HREADY = bus[i].HREADYOUT;
        assign bus[i].HADDR  = haddr;
        assign bus[i].HTRANS = htrans;
        assign bus[i].HWRITE = hwrite;
        assign bus[i].HSIZE  = hsize;
        assign bus[i].HWDATA = 32'h5555_AAAA;

        assign rdy[i]   = bus[i].HREADYOUT;
        assign resp[i]  = bus[i].HRESP;
        assign rdata[i] = bus[i].HRDATA;

        ahb_banked_rom #(
            .MEMWIDTH   (14),
            .NBANKS     (4),
            .WAIT_STATES(WS),
            .ROM_FILE   ("")
        ) dut (
            .HCLK  (clk),
            .HRESET(rsts[i]),
            .bus   (bus[i])
        );

        assign ben[i] = dut.bank_en;

        initial begin
            dut.rom[0]     = 32'hA0A0_A0A0;
            dut.rom[5]     = 32'hCAFE_F00D;
            dut.rom[6]     = 32'h1234_5678;
            dut.rom[8]     = 32'hDEAD_BEEF;
            dut.rom[12'h400] = 32'hB1B1_B1B1;
            dut.rom[12'h800] = 32'hC2C2_C2C2;
            dut.rom[12'hC00] = 32'hD3D3_D3D3;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input int i, input string tag, input logic r,
                             input logic rs, input logic [31:0] d);
        check({tag, ".rdy"}, 32'(rdy[i]), 32'(r));
        check({tag, ".resp"}, 32'(resp[i]), 32'(rs));
        check({tag, ".data"}, rdata[i], d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] s, input logic [1:0] t,
                       input logic [31:0] a, input logic w,
                       input logic [2:0] sz);
        sel    = s;
        htrans = t;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        #1;
    endtask

    task automatic idle();
        drv(3'b000, 2'b00, 32'h0, 1'b0, 3'd2);
    endtask

    task automatic rd(input int i, input logic [31:0] a);
        drv(3'(1 << i), 2'b10, a, 1'b0, 3'd2);
    endtask

    logic [31:0] ta [5] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000, 32'h4000};
    logic [3:0]  te [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] td [5] = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2,
                            32'hD3D3_D3D3, 32'hA0A0_A0A0};
    logic        er [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int pulses;
        rsts = 3'b111;
        sel    = '0;
        htrans = '0;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = 3'd2;
        repeat (3) @(posedge clk);
        #2;
        rsts = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_out(i, $sformatf("reset%0d", i), 1'b1, 1'b0, 32'h0);
            check($sformatf("reset%0d.ben", i), 32'(ben[i]), 32'h0);
        end

        // zero-wait read of word 5
        tick(); rd(0, 32'h14);
        check("t1.ben", 32'(ben[0]), 32'h1);
        tick(); idle();
        check_out(0, "t1", 1'b1, 1'b0, 32'hCAFE_F00D);
        tick();
        check_out(0, "t1.after", 1'b1, 1'b0, 32'h0);

        // bank decode, back-to-back, address wrap
        for (int k = 0; k < 5; k++) begin
            tick(); rd(0, ta[k]);
            check($sformatf("bank%0d.en", k), 32'(ben[0]), 32'(te[k]));
            if (k > 0) check($sformatf("bank%0d.data", k - 1), rdata[0], td[k - 1]);
        end
        tick(); idle();
        check("bank4.data", rdata[0], td[4]);

        // ignored transfers
        tick(); drv(3'b000, 2'b10, 32'h14, 1'b0, 3'd2);
        check("nosel.ben", 32'(ben[0]), 32'h0);
        tick(); drv(3'b001, 2'b01, 32'h14, 1'b0, 3'd2);
        check_out(0, "nosel", 1'b1, 1'b0, 32'h0);
        check("busy.ben", 32'(ben[0]), 32'h0);
        tick(); idle();
        check_out(0, "busy", 1'b1, 1'b0, 32'h0);

        // write, then read
        tick(); drv(3'b001, 2'b10, 32'h20, 1'b1, 3'd2);
        check("wr.ben", 32'(ben[0]), 32'h0);
`ifdef AHB_ROM_ERROR_EN
        tick(); idle();
        check_out(0, "wr.err1", 1'b0, 1'b1, 32'h0);
        tick(); rd(0, 32'h14);
        check_out(0, "wr.err2", 1'b1, 1'b1, 32'h0);
        check("wr.err2.ben", 32'(ben[0]), 32'h1);
`else
        tick(); rd(0, 32'h14);
        check_out(0, "wr.okay", 1'b1, 1'b0, 32'h0);
`endif
        tick(); idle();
        check_out(0, "wr.next", 1'b1, 1'b0, 32'hCAFE_F00D);

        // misaligned word and aligned halfword
        tick(); drv(3'b001, 2'b10, 32'h15, 1'b0, 3'd2);
`ifdef AHB_ROM_ERROR_EN
        check("mis.ben", 32'(ben[0]), 32'h0);
        tick(); idle();
        check_out(0, "mis.err1", 1'b0, 1'b1, 32'h0);
        tick();
        check_out(0, "mis.err2", 1'b1, 1'b1, 32'h0);
`else
        check("mis.ben", 32'(ben[0]), 32'h1);
        tick(); idle();
        check_out(0, "mis.word", 1'b1, 1'b0, 32'hCAFE_F00D);
`endif
        tick(); drv(3'b001, 2'b10, 32'h16, 1'b0, 3'd1);
        tick(); idle();
        check_out(0, "half", 1'b1, 1'b0, 32'hCAFE_F00D);

        // two wait states, back-to-back reads
        tick(); rd(1, 32'h14);
        pulses = (ben[1] != 0) ? 1 : 0;
        check("ws2.c0.ben", 32'(ben[1]), 32'h1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 3) rd(1, 32'h18);
            else idle();
            check($sformatf("ws2.c%0d.rdy", c), 32'(rdy[1]), 32'(er[c]));
            check($sformatf("ws2.c%0d.data", c), rdata[1],
                  (c == 3) ? 32'hCAFE_F00D : ((c == 6) ? 32'h1234_5678 : 32'h0));
            check($sformatf("ws2.c%0d.ben", c), 32'(ben[1]),
                  (c == 3) ? 32'h1 : 32'h0);
            if (ben[1] != 0) pulses++;
        end
        check("ws2.pulses", 32'(pulses), 32'd2);

        // reset pulse in the second wait cycle
        tick(); rd(2, 32'h14);
        tick(); idle();
        check_out(2, "ws3.w1", 1'b0, 1'b0, 32'h0);
        tick();
        check_out(2, "ws3.w2", 1'b0, 1'b0, 32'h0);
        rsts[2] = 1'b1;
        #1;
        check_out(2, "ws3.rst", 1'b1, 1'b0, 32'h0);
        rsts[2] = 1'b0;
        tick();
        check_out(2, "ws3.idle", 1'b1, 1'b0, 32'h0);
        rd(2, 32'h18);
        for (int c = 1; c <= 4; c++) begin
            tick(); idle();
            check_out(2, $sformatf("ws3.c%0d", c), (c == 4), 1'b0,
                      (c == 4) ? 32'h1234_5678 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
